// File: rtl/qpu_exu_oitf.sv
`default_nettype none
//============================================================================
// Module   : qpu_exu_oitf
// Brief    : Outstanding-instruction track FIFO for long-pipe operations.
//            Tracks the destination register and qubit list of each
//            instruction still in flight, and reports hazards to dispatch.
// Revision : 1.0 - initial release
//============================================================================

`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 4
`endif

module qpu_exu_oitf #(
  parameter int OITF_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  // dispatch / allocate side
  input  logic                              dis_ena,
  output logic                              dis_ready,
  input  logic                              disp_i_rs1en,
  input  logic                              disp_i_rs2en,
  input  logic                              disp_i_rdwen,
  input  logic                              disp_i_qfren,
  input  logic [`QPU_RFIDX_REAL_WIDTH-1:0]  disp_i_rs1idx,
  input  logic [`QPU_RFIDX_REAL_WIDTH-1:0]  disp_i_rs2idx,
  input  logic [`QPU_RFIDX_REAL_WIDTH-1:0]  disp_i_rdidx,
  input  logic [`QPU_QUBIT_NUM-1:0]         disp_i_qubitlist,
  // hazard indications
  output logic                              oitfrd_match_disprs1,
  output logic                              oitfrd_match_disprs2,
  output logic                              oitfrd_match_disprd,
  output logic                              oitfqf_match_dispql,
  // retire side
  input  logic                              ret_ena,
  output logic                              ret_rdwen,
  output logic [`QPU_RFIDX_REAL_WIDTH-1:0]  ret_rdidx,
  output logic                              ret_qfren,
  output logic [`QPU_QUBIT_NUM-1:0]         ret_qubitlist,
  // pointers and status
  output logic [$clog2(OITF_DEPTH)-1:0]     dis_ptr,
  output logic [$clog2(OITF_DEPTH)-1:0]     ret_ptr,
  output logic                              oitf_empty
);

  localparam int c_PTR_W = $clog2(OITF_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(OITF_DEPTH - 1);

  // Pointer state: index plus wrap flag distinguishing full from empty.
  logic [c_PTR_W-1:0] r_dis_ptr;
  logic [c_PTR_W-1:0] r_ret_ptr;
  logic               r_dis_flag;
  logic               r_ret_flag;

  // Entry storage; only valid bits are reset, payload is qualified by valid.
  logic [OITF_DEPTH-1:0]             r_vld;
  logic [OITF_DEPTH-1:0]             r_rdwen;
  logic [OITF_DEPTH-1:0]             r_qfren;
  logic [`QPU_RFIDX_REAL_WIDTH-1:0]  r_rdidx [OITF_DEPTH];
  logic [`QPU_QUBIT_NUM-1:0]         r_ql    [OITF_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_alloc;
  logic w_ret;

  assign w_empty = (r_dis_ptr == r_ret_ptr) && (r_dis_flag == r_ret_flag);
  assign w_full  = (r_dis_ptr == r_ret_ptr) && (r_dis_flag != r_ret_flag);

  // Readiness depends only on the registered full state, so a retire in the
  // same cycle never opens a slot for a dispatch in that cycle.
  assign dis_ready  = ~w_full;
  assign oitf_empty = w_empty;
  assign w_alloc    = dis_ena & ~w_full;
  assign w_ret      = ret_ena & ~w_empty;

  assign dis_ptr = r_dis_ptr;
  assign ret_ptr = r_ret_ptr;

  // Pointer advance and valid-bit bookkeeping, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dis_ptr  <= '0;
      r_ret_ptr  <= '0;
      r_dis_flag <= 1'b0;
      r_ret_flag <= 1'b0;
      r_vld      <= '0;
    end else begin
      if (w_alloc) begin
        r_vld[r_dis_ptr] <= 1'b1;
        if (r_dis_ptr == c_LAST) begin
          r_dis_ptr  <= '0;
          r_dis_flag <= ~r_dis_flag;
        end else begin
          r_dis_ptr <= r_dis_ptr + 1'b1;
        end
      end
      // Allocate and retire never target the same slot: that would need the
      // FIFO to be both not-full and not-empty at equal pointers.
      if (w_ret) begin
        r_vld[r_ret_ptr] <= 1'b0;
        if (r_ret_ptr == c_LAST) begin
          r_ret_ptr  <= '0;
          r_ret_flag <= ~r_ret_flag;
        end else begin
          r_ret_ptr <= r_ret_ptr + 1'b1;
        end
      end
    end
  end

  // Capture the dispatched instruction's payload into the allocated slot.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_rdwen[r_dis_ptr] <= disp_i_rdwen;
      r_qfren[r_dis_ptr] <= disp_i_qfren;
      r_rdidx[r_dis_ptr] <= disp_i_rdidx;
      r_ql[r_dis_ptr]    <= disp_i_qubitlist;
    end
  end

  // Head entry is presented to writeback without a register stage.
  assign ret_rdwen     = r_rdwen[r_ret_ptr];
  assign ret_qfren     = r_qfren[r_ret_ptr];
  assign ret_rdidx     = r_rdidx[r_ret_ptr];
  assign ret_qubitlist = r_ql[r_ret_ptr];

  // Per-entry hazard comparisons against the instruction at dispatch.
  logic [OITF_DEPTH-1:0] w_rs1_hit;
  logic [OITF_DEPTH-1:0] w_rs2_hit;
  logic [OITF_DEPTH-1:0] w_rd_hit;
  logic [OITF_DEPTH-1:0] w_ql_hit;

  genvar gi;
  generate
    for (gi = 0; gi < OITF_DEPTH; gi++) begin : g_entry
      logic w_wr_live;
      assign w_wr_live     = r_vld[gi] & r_rdwen[gi];
      assign w_rs1_hit[gi] = w_wr_live & (r_rdidx[gi] == disp_i_rs1idx);
      assign w_rs2_hit[gi] = w_wr_live & (r_rdidx[gi] == disp_i_rs2idx);
      assign w_rd_hit[gi]  = w_wr_live & (r_rdidx[gi] == disp_i_rdidx);
      assign w_ql_hit[gi]  = r_vld[gi] & r_qfren[gi] &
                             (|(r_ql[gi] & disp_i_qubitlist));
    end
  endgenerate

  assign oitfrd_match_disprs1 = disp_i_rs1en & (|w_rs1_hit);
  assign oitfrd_match_disprs2 = disp_i_rs2en & (|w_rs2_hit);
  assign oitfrd_match_disprd  = disp_i_rdwen & (|w_rd_hit);
  assign oitfqf_match_dispql  = |w_ql_hit;

endmodule

`default_nettype wire
